// File: rtl/ram_port_master_pkg.sv
// Shared types and helpers for the RAM port initiator.
// Its state encoding, the full-word byte-enable constant and the alignment predicate
// are used when RAM_PORT_MASTER_MISALIGN_CHK_EN is defined.
package ram_port_master_pkg;

    typedef enum logic [1:0] {
        RPM_IDLE   = 2'd0,
        RPM_RESP   = 2'd1,
        RPM_RMW_WR = 2'd2
    } rpm_state_e;

    localparam logic [3:0] BE_FULL = 4'hF;

    // A full word needs a word-aligned address.
    // Halfword and byte enables must sit on their natural lanes.
    // An empty enable set never touches the RAM, so it counts as aligned.
    function automatic logic be_is_aligned(input logic [3:0] be, input logic [1:0] addr_lo);
        logic ok;
        case (be)
            BE_FULL:                     ok = (addr_lo == 2'b00);
            4'b0011, 4'b1100:            ok = 1'b1;
            4'b0001, 4'b0010,
            4'b0100, 4'b1000:            ok = 1'b1;
            4'b0000:                     ok = 1'b1;
            default:                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ram_port_master_be_merge.sv
// Per-byte mux: new store bytes where be is set, old RAM bytes elsewhere.
module be_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);

    for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_byte
        assign merged_o[gi*8 +: 8] = be_i[gi] ? wdata_i[gi*8 +: 8] : rdata_i[gi*8 +: 8];
    end

endmodule

// File: rtl/ram_port_master.sv
// Core-side req/gnt/rvalid initiator for a single-port, no-change-mode word RAM.
// Partial stores are emulated with a read-modify-write sequence, because the RAM has no byte enables.
// Optional misalignment checking is enabled by defining RAM_PORT_MASTER_MISALIGN_CHK_EN.
module ram_port_master
    import ram_port_master_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req,
    output logic                gnt,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_di,
    input  logic [DATA_W-1:0]   ram_dout
);

    localparam int BE_W = DATA_W / 8;

    rpm_state_e          state_q;
    logic                rvalid_q;
    logic                load_q;
    logic                err_q;
    logic [ADDR_W-3:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merged;

    logic                can_acc;
    logic                is_full;
    logic                is_zero;
    logic                misalign;

    // Reset blocks new grants, and it also blocks the RMW write in the same cycle.
    assign can_acc = rstn && ((state_q == RPM_IDLE) || (state_q == RPM_RESP));
    assign gnt     = req && can_acc;
    assign is_full = &be;
    assign is_zero = ~|be;

`ifdef RAM_PORT_MASTER_MISALIGN_CHK_EN
    assign misalign = we ? !be_is_aligned(be[3:0], addr[1:0]) : (addr[1:0] != 2'b00);
`else
    logic unused_addr_lo;
    assign misalign       = 1'b0;
    assign unused_addr_lo = ^addr[1:0];
`endif

    be_merge #(.DATA_W(DATA_W)) u_merge (
        .wdata_i  (wdata_q),
        .rdata_i  (ram_dout),
        .be_i     (be_q),
        .merged_o (merged)
    );

    // RAM strobes are driven straight from the accepted request, or from the latched RMW context.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (state_q == RPM_RMW_WR) begin
            if (rstn) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = {addr_q, 2'b00};
                ram_di   = merged;
            end
        end else if (gnt && !misalign) begin
            if (!we) begin
                ram_en   = 1'b1;
                ram_addr = {addr[ADDR_W-1:2], 2'b00};
            end else if (is_full) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = {addr[ADDR_W-1:2], 2'b00};
                ram_di   = wdata;
            end else if (!is_zero) begin
                ram_en   = 1'b1;
                ram_addr = {addr[ADDR_W-1:2], 2'b00};
            end
        end
    end

    // The FSM and response registers advance on each accepted request, or on completion of the RMW write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= RPM_IDLE;
            rvalid_q <= 1'b0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                RPM_RMW_WR: begin
                    state_q  <= RPM_RESP;
                    rvalid_q <= 1'b1;
                    load_q   <= 1'b0;
                    err_q    <= 1'b0;
                end
                default: begin
                    if (gnt) begin
                        if (misalign) begin
                            state_q  <= RPM_RESP;
                            rvalid_q <= 1'b1;
                            load_q   <= 1'b0;
                            err_q    <= 1'b1;
                        end else if (we && !is_full && !is_zero) begin
                            state_q  <= RPM_RMW_WR;
                            rvalid_q <= 1'b0;
                            load_q   <= 1'b0;
                            err_q    <= 1'b0;
                            addr_q   <= addr[ADDR_W-1:2];
                            be_q     <= be;
                            wdata_q  <= wdata;
                        end else begin
                            state_q  <= RPM_RESP;
                            rvalid_q <= 1'b1;
                            load_q   <= !we;
                            err_q    <= 1'b0;
                        end
                    end else begin
                        state_q  <= RPM_IDLE;
                        rvalid_q <= 1'b0;
                        load_q   <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Load data comes straight from the RAM output register during the response cycle.
    assign rvalid = rvalid_q && rstn;
    assign rdata  = (rvalid && load_q) ? ram_dout : '0;
    assign err    = rvalid && err_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master, paired with a behavioural no-change-mode RAM.
// It checks for misaligned-access errors when RAM_PORT_MASTER_MISALIGN_CHK_EN is defined.
module tb_ram_port_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout = 32'h0;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ram_port_master #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .gnt      (gnt),
        .we       (we),
        .be       (be),
        .addr     (addr),
        .wdata    (wdata),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .err      (err),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_dout (ram_dout)
    );

    // No-change mode: dout holds its value across writes.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[9:2]] <= ram_di;
            else        ram_dout <= mem[ram_addr[9:2]];
        end
    end

    always @(posedge clk) begin
        if (ram_en && ram_we) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic r, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d);
        req   = r;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h00000111;
        mem[1]  = 32'h00000222;
        mem[2]  = 32'h00000333;
        mem[8]  = 32'h11223344;   // 0x20
        mem[12] = 32'h55555555;   // 0x30
        mem[16] = 32'hCAFEF00D;   // 0x40

        rstn = 1'b0;
        set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset held three cycles with req asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_gnt", {31'd0, gnt}, 32'd0);
            chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
            chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        end
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        $display("txn reset held 3 cycles");

        @(negedge clk);
        rstn = 1'b1;
        set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Full store followed by a load of the same word
        @(negedge clk);
        set_req(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        #1;
        chk("fs_gnt", {31'd0, gnt}, 32'd1);
        chk("fs_ram_en", {31'd0, ram_en}, 32'd1);
        chk("fs_ram_we", {31'd0, ram_we}, 32'd1);
        chk("fs_ram_addr", ram_addr, 32'h10);
        chk("fs_ram_di", ram_di, 32'hDEADBEEF);
        $display("txn store addr=0x10 be=f data=deadbeef");
        post_edge();
        chk("fs_rvalid", {31'd0, rvalid}, 32'd1);
        chk("fs_rdata", rdata, 32'd0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        #1;
        chk("ld10_gnt", {31'd0, gnt}, 32'd1);
        chk("ld10_ram_we", {31'd0, ram_we}, 32'd0);
        post_edge();
        chk("ld10_rvalid", {31'd0, rvalid}, 32'd1);
        chk("ld10_rdata", rdata, 32'hDEADBEEF);
        chk("ld10_wr_cnt", wr_cnt, 32'd1);
        $display("txn load addr=0x10 rdata=%h", rdata);
        @(negedge clk);
        set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("idle_ram_en", {31'd0, ram_en}, 32'd0);
        post_edge();
        chk("idle_rvalid", {31'd0, rvalid}, 32'd0);

        // Partial store: read phase, then write phase
        @(negedge clk);
        set_req(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00);
        #1;
        chk("ps_gnt", {31'd0, gnt}, 32'd1);
        chk("ps_rd_en", {31'd0, ram_en}, 32'd1);
        chk("ps_rd_we", {31'd0, ram_we}, 32'd0);
        post_edge();
        chk("ps_t1_rvalid", {31'd0, rvalid}, 32'd0);
        @(negedge clk); #1;
        chk("ps_t1_gnt", {31'd0, gnt}, 32'd0);
        chk("ps_wr_en", {31'd0, ram_en}, 32'd1);
        chk("ps_wr_we", {31'd0, ram_we}, 32'd1);
        chk("ps_wr_addr", ram_addr, 32'h20);
        chk("ps_wr_di", ram_di, 32'h1122AB44);
        post_edge();
        chk("ps_t2_rvalid", {31'd0, rvalid}, 32'd1);
        chk("ps_t2_rdata", rdata, 32'd0);
        $display("txn store addr=0x20 be=2 data=0000ab00");
        @(negedge clk);
        set_req(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        #1;
        chk("ld20_gnt", {31'd0, gnt}, 32'd1);
        post_edge();
        chk("ld20_rvalid", {31'd0, rvalid}, 32'd1);
        chk("ld20_rdata", rdata, 32'h1122AB44);
        $display("txn load addr=0x20 rdata=%h", rdata);

        // Back-to-back loads
        @(negedge clk);
        set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("bb0_gnt", {31'd0, gnt}, 32'd1);
        post_edge();
        chk("bb0_rvalid", {31'd0, rvalid}, 32'd1);
        chk("bb0_rdata", rdata, 32'h00000111);
        $display("txn load addr=0x0 rdata=%h", rdata);
        @(negedge clk);
        set_req(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        #1;
        chk("bb4_gnt", {31'd0, gnt}, 32'd1);
        post_edge();
        chk("bb4_rvalid", {31'd0, rvalid}, 32'd1);
        chk("bb4_rdata", rdata, 32'h00000222);
        $display("txn load addr=0x4 rdata=%h", rdata);
        @(negedge clk);
        set_req(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        #1;
        chk("bb8_gnt", {31'd0, gnt}, 32'd1);
        post_edge();
        chk("bb8_rvalid", {31'd0, rvalid}, 32'd1);
        chk("bb8_rdata", rdata, 32'h00000333);
        $display("txn load addr=0x8 rdata=%h", rdata);
        @(negedge clk);
        set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        post_edge();
        chk("bb_end_rvalid", {31'd0, rvalid}, 32'd0);

        // Reset while the RMW write is pending
        @(negedge clk);
        set_req(1'b1, 1'b1, 4'b0001, 32'h30, 32'h000000FF);
        post_edge();
        chk("rmw_rst_t1_rvalid", {31'd0, rvalid}, 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rmw_rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rmw_rst_ram_we", {31'd0, ram_we}, 32'd0);
        post_edge();
        chk("rmw_rst_rvalid", {31'd0, rvalid}, 32'd0);
        $display("txn store addr=0x30 be=1 aborted by reset");
        @(negedge clk);
        rstn = 1'b1;
        set_req(1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
        post_edge();
        chk("ld30_rvalid", {31'd0, rvalid}, 32'd1);
        chk("ld30_rdata", rdata, 32'h55555555);
        $display("txn load addr=0x30 rdata=%h", rdata);

        // Store with no byte enables touches nothing
        @(negedge clk);
        set_req(1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF);
        #1;
        chk("be0_gnt", {31'd0, gnt}, 32'd1);
        chk("be0_ram_en", {31'd0, ram_en}, 32'd0);
        post_edge();
        chk("be0_rvalid", {31'd0, rvalid}, 32'd1);
        chk("be0_rdata", rdata, 32'd0);
        chk("be0_wr_cnt", wr_cnt, 32'd2);
        $display("txn store addr=0x30 be=0");

        // Misaligned load
        @(negedge clk);
        set_req(1'b1, 1'b0, 4'h0, 32'h42, 32'h0);
        #1;
`ifdef RAM_PORT_MASTER_MISALIGN_CHK_EN
        chk("mis_ram_en", {31'd0, ram_en}, 32'd0);
        post_edge();
        chk("mis_rvalid", {31'd0, rvalid}, 32'd1);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_rdata", rdata, 32'd0);
`else
        chk("mis_ram_en", {31'd0, ram_en}, 32'd1);
        chk("mis_ram_addr", ram_addr, 32'h40);
        post_edge();
        chk("mis_rvalid", {31'd0, rvalid}, 32'd1);
        chk("mis_err", {31'd0, err}, 32'd0);
        chk("mis_rdata", rdata, 32'hCAFEF00D);
`endif
        $display("txn load addr=0x42 rdata=%h err=%0d", rdata, err);

        @(negedge clk);
        set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        post_edge();
        chk("final_rvalid", {31'd0, rvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
